fetch_buf: RTL and testbench
============================

# fetch_buf

Parametrised fetch stage with a decoupling instruction queue, the next generation of the single-instruction fetch stage. It owns the fetch PC and issues aligned multi-instruction fetch requests to the I-cache. Returned instructions go into a circular queue with their PC+4. Decode drains the queue at up to `POP_WIDTH` instructions per cycle. Branch/exception redirects flush the queue and discard any in-flight response.

## Interface
Parameters:
- `FETCH_WIDTH`, 2: instructions per I-cache response; power of 2.
- `DEPTH`, 8: queue entries; power of 2, ≥ 2·`FETCH_WIDTH`.
- `POP_WIDTH`, 2: maximum instructions dequeued per cycle; ≤ `DEPTH`.
- `RESET_PC`, 32'hbfc0_0000: fetch PC after reset.

Ports:
- `clk` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high.
- `ireq_valid` out 1: fetch request valid.
- `ireq_ready` in 1: I-cache accepts the request.
- `ireq_addr` out 32: block-aligned fetch address (low log2(`FETCH_WIDTH`)+2 bits zero).
- `iresp_valid` in 1: response for the single outstanding request.
- `iresp_data` in 32·`FETCH_WIDTH`: instructions; slot i is at byte `ireq_addr`+4i.
- `redirect_valid` in 1: flush and refetch.
- `redirect_pc` in 32: new PC, word aligned.
- `deq_valid` out `POP_WIDTH`: per-slot valid; contiguous from slot 0.
- `deq_instr` out 32·`POP_WIDTH`: head instructions, oldest in slot 0.
- `deq_pcplus4` out 32·`POP_WIDTH`: PC+4 of each slot.
- `deq_take` in clog2(`POP_WIDTH`+1): number consumed this cycle; must be ≤ popcount(`deq_valid`).
- `count` out clog2(`DEPTH`+1): current occupancy.

## Operation
- State: `pc` (32), queue storage of {instr, pcplus4} × `DEPTH`, `head`/`tail` pointers of log2(`DEPTH`) bits that wrap mod `DEPTH`, `count`, and FSM ∈ {IDLE, WAIT, DROP}.
- `ireq_valid` = (IDLE) ∧ (`DEPTH`−`count` ≥ `FETCH_WIDTH`) ∧ ¬`redirect_valid` ∧ ¬`reset`.
- `ireq_addr` = `pc` with the low block-offset bits cleared.
- The FSM remembers the first valid slot: f = `pc`[log2(`FETCH_WIDTH`)+1:2].
- IDLE → WAIT when `ireq_valid` ∧ `ireq_ready`. The slot offset f is latched at this point.
- WAIT with `iresp_valid`:
  - push slots f..`FETCH_WIDTH`−1 at `tail`, in order; pcplus4 = block address + 4i + 4;
  - `pc` ← block address + 4·`FETCH_WIDTH`;
  - → IDLE.
- Free space is checked at request time against the registered `count`, so a response never overflows the queue.
- Dequeue: `head` advances by `deq_take`. Next `count` = `count` + pushed − `deq_take`; push and pop in the same cycle are legal.
- Redirect (`redirect_valid`=1), which has priority over all other events:
  - queue cleared (`head`=`tail`, `count`=0);
  - `pc` ← `redirect_pc`;
  - `deq_take` and any same-cycle response are ignored;
  - FSM: WAIT without `iresp_valid` → DROP; WAIT with `iresp_valid` → IDLE; IDLE → IDLE; DROP stays DROP.
- DROP: no request is issued. On `iresp_valid` the data is discarded and the FSM → IDLE.
- The `deq_*` outputs are combinational reads of the registered queue at `head`+i. Slot i is valid iff i < `count`.
- Reset clears the queue, sets `pc`=`RESET_PC` and the FSM=IDLE. All outputs are 0 while `reset`=1, including `count`=0 and `deq_valid`=0.
- Reset during WAIT/DROP goes straight to IDLE; the I-cache is reset concurrently.

## Timing
- Request accepted at cycle t; the response arrives at cycle ≥ t+1. Pushed instructions appear on `deq_*` at the cycle after the response.
- Latency with no stalls: `ireq` at t, response at t+1, `deq_valid` at t+2. The next request can issue at t+2.
- Redirect at cycle t:
  - queue empty (`deq_valid`=0) at t+1;
  - if the FSM is IDLE at t+1, `ireq_addr` is the aligned `redirect_pc` at t+1.
- Full queue: `ireq_valid` stays 0 until `count` ≤ `DEPTH`−`FETCH_WIDTH`.
- Pointer wrap: a push that straddles index `DEPTH`−1 continues at index 0.

## Test plan
- Reset, then `ireq_ready`=1 and a 1-cycle response: first `ireq_addr`=0xbfc0_0000. After the response, `deq_valid`=2'b11 and `deq_pcplus4`={0xbfc0_0008, 0xbfc0_0004}. The next `ireq_addr` is 0xbfc0_0008.
- Redirect to 0x8000_0004 (unaligned): `ireq_addr`=0x8000_0000. Only slot 1 is pushed, so `count`=1 and `deq_pcplus4`[0]=0x8000_0008.
- `deq_take`=0 for many cycles: `count` reaches 8, then `ireq_valid`=0. With `deq_take`=2 for one cycle the request resumes, and in-order contents survive `tail` wrap.
- Redirect while in WAIT, response 3 cycles later: the response is discarded (`count` stays 0). The next request is issued at the redirect PC only after the dropped response.
- Redirect and `iresp_valid` in the same cycle, with `deq_take`=2: the queue is empty next cycle, the FSM is IDLE, and `ireq_addr`=`redirect_pc`.
- Simultaneous push of 2 and `deq_take`=1 with `count`=3: `count`=4 next cycle and order is preserved.

Source files
------------

// File: rtl/fetch_buf.sv
// Fetch stage with a decoupling instruction queue: owns the fetch PC, issues
// aligned block requests to the I-cache and buffers returned instructions for decode.
module fetch_buf #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned POP_WIDTH   = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             ireq_valid,
    input  logic                             ireq_ready,
    output logic [31:0]                      ireq_addr,
    input  logic                             iresp_valid,
    input  logic [32*FETCH_WIDTH-1:0]        iresp_data,
    input  logic                             redirect_valid,
    input  logic [31:0]                      redirect_pc,
    output logic [POP_WIDTH-1:0]             deq_valid,
    output logic [32*POP_WIDTH-1:0]          deq_instr,
    output logic [32*POP_WIDTH-1:0]          deq_pcplus4,
    input  logic [$clog2(POP_WIDTH+1)-1:0]   deq_take,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned SLOT_W   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] BLK_BYTES = 32'(FETCH_WIDTH * 4);
    localparam logic [31:0] BLK_MASK  = ~(BLK_BYTES - 32'd1);
    localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_WIDTH);
    localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(DEPTH - FETCH_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        pc_r;
    logic [31:0]        pc_next_s;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   head_next_s;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W-1:0]   tail_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [SLOT_W-1:0]  slot_r;
    logic [SLOT_W-1:0]  first_slot_s;
    logic [31:0]        blk_s;
    logic               ireq_valid_s;
    logic               req_fire_s;
    logic               push_en_s;
    logic [CNT_W-1:0]   push_n_s;
    logic [CNT_W-1:0]   take_ext_s;
    logic [CNT_W-1:0]   take_eff_s;

    logic [31:0]        instr_mem_r [DEPTH];
    logic [31:0]        pcp4_mem_r  [DEPTH];

    assign blk_s        = pc_r & BLK_MASK;
    assign first_slot_s = SLOT_W'((pc_r >> 2) & 32'(FETCH_WIDTH - 1));
    assign take_ext_s   = CNT_W'(deq_take);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a redirect while waiting turns the in-flight response into a drop
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (iresp_valid) begin
                    state_next_s = ST_IDLE;
                end else if (redirect_valid) begin
                    state_next_s = ST_DROP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (iresp_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request issue and response acceptance
    always_comb begin
        ireq_valid_s = 1'b0;
        push_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ireq_valid_s = (count_r <= REQ_LIMIT) && !redirect_valid && !reset;
            end
            ST_WAIT: begin
                push_en_s = iresp_valid && !redirect_valid && !reset;
            end
            ST_DROP: begin
                ireq_valid_s = 1'b0;
            end
            default: begin
                ireq_valid_s = 1'b0;
                push_en_s    = 1'b0;
            end
        endcase
    end

    assign req_fire_s = ireq_valid_s && ireq_ready;

    // Next pointers, occupancy and PC; the take is clamped to the valid head slots
    always_comb begin
        push_n_s     = '0;
        take_eff_s   = '0;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        pc_next_s    = pc_r;
        if (redirect_valid) begin
            head_next_s  = '0;
            tail_next_s  = '0;
            count_next_s = '0;
            pc_next_s    = redirect_pc;
        end else begin
            if (push_en_s) begin
                push_n_s  = FETCH_CNT - CNT_W'(slot_r);
                pc_next_s = blk_s + BLK_BYTES;
            end else begin
                push_n_s  = '0;
                pc_next_s = pc_r;
            end
            if (take_ext_s > count_r) begin
                take_eff_s = count_r;
            end else begin
                take_eff_s = take_ext_s;
            end
            head_next_s  = head_r + PTR_W'(take_eff_s);
            tail_next_s  = tail_r + PTR_W'(push_n_s);
            count_next_s = count_r + push_n_s - take_eff_s;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            slot_r  <= '0;
        end else begin
            pc_r    <= pc_next_s;
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            if (req_fire_s) begin
                slot_r <= first_slot_s;
            end else begin
                slot_r <= slot_r;
            end
        end
    end

    // Queue storage; entries are only observed when covered by count, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (push_en_s && (SLOT_W'(i) >= slot_r)) begin
                instr_mem_r[tail_r + PTR_W'(i) - PTR_W'(slot_r)] <= iresp_data[32*i +: 32];
                pcp4_mem_r[tail_r + PTR_W'(i) - PTR_W'(slot_r)]  <= blk_s + 32'(4 * i + 4);
            end
        end
    end

    // Decode-facing head window and status outputs, forced to zero in reset
    always_comb begin
        deq_valid   = '0;
        deq_instr   = '0;
        deq_pcplus4 = '0;
        ireq_valid  = 1'b0;
        ireq_addr   = 32'd0;
        count       = '0;
        if (!reset) begin
            ireq_valid = ireq_valid_s;
            ireq_addr  = blk_s;
            count      = count_r;
            for (int i = 0; i < POP_WIDTH; i++) begin
                deq_valid[i]            = (CNT_W'(i) < count_r);
                deq_instr[32*i +: 32]   = instr_mem_r[head_r + PTR_W'(i)];
                deq_pcplus4[32*i +: 32] = pcp4_mem_r[head_r + PTR_W'(i)];
            end
        end else begin
            deq_valid   = '0;
            deq_instr   = '0;
            deq_pcplus4 = '0;
            ireq_valid  = 1'b0;
            ireq_addr   = 32'd0;
            count       = '0;
        end
    end

endmodule

// File: tb/tb_fetch_buf.sv
// Directed bench for fetch_buf: a per-cycle vector table for the main flow plus
// hand-written sequences for queue wrap, dropped responses, redirect races and reset.
module tb_fetch_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic        ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [63:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  deq_valid;
    logic [63:0] deq_instr;
    logic [63:0] deq_pcplus4;
    logic [1:0]  deq_take;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic        rd;
        logic [31:0] rpc;
        logic [63:0] data;
        logic [1:0]  take;
        logic        e_iv;
        logic [31:0] e_addr;
        logic [1:0]  e_dv;
        logic [3:0]  e_cnt;
        logic [31:0] e_i0;
        logic [31:0] e_p0;
        logic [31:0] e_i1;
        logic [31:0] e_p1;
    } vec_t;

    vec_t vq[$];

    fetch_buf dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_ready    (ireq_ready),
        .ireq_addr     (ireq_addr),
        .iresp_valid   (iresp_valid),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .deq_valid     (deq_valid),
        .deq_instr     (deq_instr),
        .deq_pcplus4   (deq_pcplus4),
        .deq_take      (deq_take),
        .count         (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_slot(input string name, input int s, input logic [31:0] ei, input logic [31:0] ep);
        chk({name, "_instr"}, {32'd0, deq_instr[32*s +: 32]}, {32'd0, ei});
        chk({name, "_pcp4"}, {32'd0, deq_pcplus4[32*s +: 32]}, {32'd0, ep});
    endtask

    task automatic add(input logic rdy, input logic rv, input logic rd, input logic [31:0] rpc,
                       input logic [63:0] data, input logic [1:0] take, input logic e_iv,
                       input logic [31:0] e_addr, input logic [1:0] e_dv, input logic [3:0] e_cnt,
                       input logic [31:0] e_i0, input logic [31:0] e_p0,
                       input logic [31:0] e_i1, input logic [31:0] e_p1);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.rpc = rpc; v.data = data; v.take = take;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_dv = e_dv; v.e_cnt = e_cnt;
        v.e_i0 = e_i0; v.e_p0 = e_p0; v.e_i1 = e_i1; v.e_p1 = e_p1;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc;

        reset = 1'b1; ireq_ready = 1'b1; iresp_valid = 1'b0; iresp_data = 64'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; deq_take = 2'd0;
        next_cycle();
        next_cycle();
        #2;
        chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("rst_ireq_addr", {32'd0, ireq_addr}, 64'd0);
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_deq_valid", {62'd0, deq_valid}, 64'd0);
        chk("rst_deq_instr", deq_instr, 64'd0);
        chk("rst_deq_pcp4", deq_pcplus4, 64'd0);

        // rdy rv rd rpc data take | iv addr dv cnt i0 p0 i1 p1
        add(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'hbfc0_0000, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'd0, {32'h0000_1001, 32'h0000_1000}, 2'd0, 1'b0, 32'hbfc0_0000, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'hbfc0_0008, 2'b11, 4'd2, 32'h0000_1000, 32'hbfc0_0004, 32'h0000_1001, 32'hbfc0_0008);
        add(1'b0, 1'b1, 1'b0, 32'd0, {32'h0000_2001, 32'h0000_2000}, 2'd1, 1'b0, 32'hbfc0_0008, 2'b11, 4'd2, 32'h0000_1000, 32'hbfc0_0004, 32'h0000_1001, 32'hbfc0_0008);
        add(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'hbfc0_0010, 2'b11, 4'd3, 32'h0000_1001, 32'hbfc0_0008, 32'h0000_2000, 32'hbfc0_000c);
        add(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'hbfc0_0010, 2'b11, 4'd3, 32'h0000_1001, 32'hbfc0_0008, 32'h0000_2000, 32'hbfc0_000c);
        add(1'b0, 1'b1, 1'b0, 32'd0, {32'h0000_3001, 32'h0000_3000}, 2'd1, 1'b0, 32'hbfc0_0010, 2'b11, 4'd3, 32'h0000_1001, 32'hbfc0_0008, 32'h0000_2000, 32'hbfc0_000c);
        add(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'd2, 1'b1, 32'hbfc0_0018, 2'b11, 4'd4, 32'h0000_2000, 32'hbfc0_000c, 32'h0000_2001, 32'hbfc0_0010);
        add(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'd2, 1'b1, 32'hbfc0_0018, 2'b11, 4'd2, 32'h0000_3000, 32'hbfc0_0014, 32'h0000_3001, 32'hbfc0_0018);
        add(1'b1, 1'b0, 1'b1, 32'h8000_0004, 64'd0, 2'd0, 1'b0, 32'hbfc0_0018, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'h8000_0000, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'd0, {32'h0000_4001, 32'h0000_4000}, 2'd0, 1'b0, 32'h8000_0000, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'h8000_0008, 2'b01, 4'd1, 32'h0000_4001, 32'h8000_0008, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'd1, 1'b1, 32'h8000_0008, 2'b01, 4'd1, 32'h0000_4001, 32'h8000_0008, 32'd0, 32'd0);
        add(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b1, 32'h8000_0008, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        next_cycle();
        reset = 1'b0;
        foreach (vq[n]) begin
            ireq_ready = vq[n].rdy; iresp_valid = vq[n].rv; iresp_data = vq[n].data;
            redirect_valid = vq[n].rd; redirect_pc = vq[n].rpc; deq_take = vq[n].take;
            #2;
            chk($sformatf("v%0d_ireq_valid", n), {63'd0, ireq_valid}, {63'd0, vq[n].e_iv});
            chk($sformatf("v%0d_ireq_addr", n), {32'd0, ireq_addr}, {32'd0, vq[n].e_addr});
            chk($sformatf("v%0d_deq_valid", n), {62'd0, deq_valid}, {62'd0, vq[n].e_dv});
            chk($sformatf("v%0d_count", n), {60'd0, count}, {60'd0, vq[n].e_cnt});
            if (vq[n].e_dv[0]) chk_slot($sformatf("v%0d_s0", n), 0, vq[n].e_i0, vq[n].e_p0);
            if (vq[n].e_dv[1]) chk_slot($sformatf("v%0d_s1", n), 1, vq[n].e_i1, vq[n].e_p1);
            next_cycle();
        end
        ireq_ready = 1'b0; iresp_valid = 1'b0; redirect_valid = 1'b0; deq_take = 2'd0;

        // Fill to full with tail wrapping past index 7, then resume and drain in order
        exp_pc = 32'h8000_0008;
        for (int k = 0; k < 4; k++) begin
            ireq_ready = 1'b1;
            #2;
            chk($sformatf("fill%0d_req_valid", k), {63'd0, ireq_valid}, 64'd1);
            chk($sformatf("fill%0d_req_addr", k), {32'd0, ireq_addr}, {32'd0, exp_pc});
            next_cycle();
            ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = {exp_pc + 32'd4, exp_pc};
            next_cycle();
            iresp_valid = 1'b0;
            exp_pc = exp_pc + 32'd8;
        end
        ireq_ready = 1'b1;
        #2;
        chk("full_count", {60'd0, count}, 64'd8);
        chk("full_no_req", {63'd0, ireq_valid}, 64'd0);
        next_cycle();
        #2;
        chk("full_no_req_hold", {63'd0, ireq_valid}, 64'd0);
        ireq_ready = 1'b0;
        deq_take = 2'd2;
        #2;
        chk_slot("full_head", 0, 32'h8000_0008, 32'h8000_000c);
        next_cycle();
        deq_take = 2'd0;
        #2;
        chk("resume_count", {60'd0, count}, 64'd6);
        chk("resume_req", {63'd0, ireq_valid}, 64'd1);
        chk("resume_addr", {32'd0, ireq_addr}, {32'd0, 32'h8000_0028});
        for (int j = 0; j < 3; j++) begin
            deq_take = 2'd2;
            #2;
            chk_slot($sformatf("drain%0d_s0", j), 0, 32'h8000_0010 + 32'(8 * j), 32'h8000_0014 + 32'(8 * j));
            chk_slot($sformatf("drain%0d_s1", j), 1, 32'h8000_0014 + 32'(8 * j), 32'h8000_0018 + 32'(8 * j));
            next_cycle();
        end
        deq_take = 2'd0;
        #2;
        chk("drained_count", {60'd0, count}, 64'd0);

        // Redirect while waiting; the late response must be dropped
        ireq_ready = 1'b1;
        #2;
        chk("drop_req_addr", {32'd0, ireq_addr}, {32'd0, 32'h8000_0028});
        next_cycle();
        ireq_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h9000_0010;
        #2;
        chk("drop_redir_no_req", {63'd0, ireq_valid}, 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ireq_ready = 1'b1;
            #2;
            chk($sformatf("drop_wait%0d_no_req", k), {63'd0, ireq_valid}, 64'd0);
            chk($sformatf("drop_wait%0d_count", k), {60'd0, count}, 64'd0);
            next_cycle();
        end
        iresp_valid = 1'b1; iresp_data = {32'hdead_0004, 32'hdead_0000};
        #2;
        chk("drop_resp_no_req", {63'd0, ireq_valid}, 64'd0);
        next_cycle();
        iresp_valid = 1'b0;
        #2;
        chk("drop_after_count", {60'd0, count}, 64'd0);
        chk("drop_after_dvalid", {62'd0, deq_valid}, 64'd0);
        chk("drop_after_req", {63'd0, ireq_valid}, 64'd1);
        chk("drop_after_addr", {32'd0, ireq_addr}, {32'd0, 32'h9000_0010});
        next_cycle();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = {32'h9000_0014, 32'h9000_0010};
        next_cycle();
        iresp_valid = 1'b0;
        #2;
        chk("refetch_count", {60'd0, count}, 64'd2);
        chk_slot("refetch_s0", 0, 32'h9000_0010, 32'h9000_0014);
        chk_slot("refetch_s1", 1, 32'h9000_0014, 32'h9000_0018);
        deq_take = 2'd2;
        next_cycle();
        deq_take = 2'd0;

        // Redirect, response and deq_take all in the same cycle
        ireq_ready = 1'b1;
        #2;
        chk("race_req1_addr", {32'd0, ireq_addr}, {32'd0, 32'h9000_0018});
        next_cycle();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = {32'h9000_001c, 32'h9000_0018};
        next_cycle();
        iresp_valid = 1'b0; ireq_ready = 1'b1;
        #2;
        chk("race_pre_count", {60'd0, count}, 64'd2);
        chk("race_pre_req", {63'd0, ireq_valid}, 64'd1);
        next_cycle();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = {32'h9000_0024, 32'h9000_0020};
        redirect_valid = 1'b1; redirect_pc = 32'ha000_0008; deq_take = 2'd2;
        next_cycle();
        iresp_valid = 1'b0; redirect_valid = 1'b0; deq_take = 2'd0;
        #2;
        chk("race_count", {60'd0, count}, 64'd0);
        chk("race_dvalid", {62'd0, deq_valid}, 64'd0);
        chk("race_req", {63'd0, ireq_valid}, 64'd1);
        chk("race_addr", {32'd0, ireq_addr}, {32'd0, 32'ha000_0008});
        ireq_ready = 1'b1;
        next_cycle();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = {32'ha000_000c, 32'ha000_0008};
        next_cycle();
        iresp_valid = 1'b0;
        #2;
        chk("race_refill_count", {60'd0, count}, 64'd2);
        chk_slot("race_refill_s0", 0, 32'ha000_0008, 32'ha000_000c);

        // Reset while waiting on a response
        ireq_ready = 1'b1;
        next_cycle();
        ireq_ready = 1'b0; reset = 1'b1;
        #2;
        chk("mrst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("mrst_ireq_addr", {32'd0, ireq_addr}, 64'd0);
        chk("mrst_count", {60'd0, count}, 64'd0);
        chk("mrst_deq_valid", {62'd0, deq_valid}, 64'd0);
        chk("mrst_deq_instr", deq_instr, 64'd0);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("post_rst_req", {63'd0, ireq_valid}, 64'd1);
        chk("post_rst_addr", {32'd0, ireq_addr}, {32'd0, 32'hbfc0_0000});
        chk("post_rst_count", {60'd0, count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
